// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/ready and decode valid/ack.
// No logic of its own; latency is set entirely by the sequencer.
// Backpressure: memory stalls via imem_ready, decode stalls via instr_ack.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch;
    logic        equal;
    logic [15:0] branch_offset;

    // Sequencer side.
    modport master (
        output imem_req, imem_addr, instr_out, instr_valid,
        input  imem_ready, imem_rdata, instr_ack, branch, equal, branch_offset
    );

    // Memory and decode side.
    modport slave (
        input  imem_req, imem_addr, instr_out, instr_valid,
        output imem_ready, imem_rdata, instr_ack, branch, equal, branch_offset
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch controller owning the PC: IDLE -> REQ -> ISSUE -> REQ/HALT, optional FETCH_STATS_EN counters.
// Latency: at least 1 cycle REQ->ISSUE; next PC is computed in the ack cycle.
// Backpressure: waits in REQ for imem_ready (timeout to HALT), holds instr_out in ISSUE until instr_ack.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    fetch_sequencer_if.master  bus,
    output logic [31:0]        pc,
    output logic               halted,
    output logic               timeout_err
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        taken_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_HALT} state_t;

    // Counter is 8 bits because TIMEOUT is limited to 1..255.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] instr_q;
    logic [31:0] pc_seq;
    logic [31:0] br_target;
    logic        br_taken;

    // Handshake outputs decode straight from state so reset clears them immediately.
    assign bus.imem_req    = (state == S_REQ);
    assign bus.instr_valid = (state == S_ISSUE);
    assign halted          = (state == S_HALT);
    assign bus.imem_addr   = pc;
    assign bus.instr_out   = instr_q;

    // Word offset is sign-extended and scaled to bytes; all sums wrap modulo 2^32.
    assign pc_seq    = pc + 32'd4;
    assign br_target = pc_seq + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign br_taken  = bus.branch & bus.equal;

    // Main sequencer: state, PC, captured instruction, memory wait counter, sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_q     <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_REQ;
                end
                S_REQ: begin
                    if (bus.imem_ready) begin
                        instr_q  <= bus.imem_rdata;
                        wait_cnt <= '0;
                        state    <= S_ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Request abandoned; pc keeps the address so start retries it.
                        timeout_err <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (bus.instr_ack) begin
                        pc    <= br_taken ? br_target : pc_seq;
                        state <= halt_req ? S_HALT : S_REQ;
                    end
                end
                S_HALT: begin
                    if (start) state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    // Free-running statistics; only reset clears them, HALT does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (state == S_REQ && bus.imem_ready)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (state == S_ISSUE && bus.instr_ack && br_taken)
                taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Transaction-level bench for fetch_sequencer: directed PC walk, then randomized fetches.
// Reference model tracks the architectural PC, sticky timeout and statistics counts.
// Each fetch drives a chosen memory latency and decode hold, then checks the outcome.
module tb_fetch_sequencer;
    localparam int          TO  = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic [31:0] pc;
    logic        halted;
    logic        timeout_err;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] taken_cnt;
`endif

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .bus         (bus),
        .pc          (pc),
        .halted      (halted),
        .timeout_err (timeout_err)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .taken_cnt   (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_pc;
    logic        m_terr;
    logic [31:0] m_fetch;
    logic [31:0] m_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_terr  = 1'b0;
        m_fetch = '0;
        m_taken = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_req", {31'd0, bus.imem_req}, 32'd1);
        check("start_pc", pc, m_pc);
        check("start_addr", bus.imem_addr, m_pc);
        check("start_terr", {31'd0, timeout_err}, {31'd0, m_terr});
    endtask

    // One fetch from REQ: lat >= TO means memory never answers.
    task automatic do_fetch(input int lat, input int hold, input logic br, input logic eq,
                            input logic [15:0] off, input logic hreq);
        logic [31:0] data;
        int          o;
        data = $urandom;
        for (int i = 0; i < TO; i++) begin
            bus.imem_ready = (i == lat);
            bus.imem_rdata = (i == lat) ? data : $urandom;
            start          = 1'($urandom_range(0, 1));
            tick();
            if (i == lat) break;
            if (i < TO - 1) check("req_wait", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ready = 1'b0;
        start          = 1'b0;
        if (lat >= TO) begin
            m_terr = 1'b1;
            check("to_halted", {31'd0, halted}, 32'd1);
            check("to_terr", {31'd0, timeout_err}, 32'd1);
            check("to_pc", pc, m_pc);
            check("to_req", {31'd0, bus.imem_req}, 32'd0);
        end else begin
            m_fetch++;
            check("iss_valid", {31'd0, bus.instr_valid}, 32'd1);
            check("iss_instr", bus.instr_out, data);
            check("iss_pc", pc, m_pc);
            check("iss_req", {31'd0, bus.imem_req}, 32'd0);
            check("iss_terr", {31'd0, timeout_err}, {31'd0, m_terr});
            for (int h = 0; h < hold; h++) begin
                bus.instr_ack     = 1'b0;
                bus.imem_rdata    = $urandom;
                bus.imem_ready    = 1'($urandom_range(0, 1));
                halt_req          = 1'($urandom_range(0, 1));
                bus.branch        = 1'($urandom_range(0, 1));
                bus.equal         = 1'($urandom_range(0, 1));
                bus.branch_offset = 16'($urandom);
                start             = 1'($urandom_range(0, 1));
                tick();
                check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
                check("hold_instr", bus.instr_out, data);
                check("hold_pc", pc, m_pc);
            end
            bus.instr_ack     = 1'b1;
            bus.branch        = br;
            bus.equal         = eq;
            bus.branch_offset = off;
            halt_req          = hreq;
            bus.imem_ready    = 1'b0;
            start             = 1'b0;
            tick();
            bus.instr_ack = 1'b0;
            halt_req      = 1'b0;
            bus.branch    = 1'b0;
            bus.equal     = 1'b0;
            if (br && eq) begin
                o = int'($signed(off));
                m_pc = m_pc + 32'd4 + 32'(o * 4);
                m_taken++;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            check("ack_pc", pc, m_pc);
            if (hreq) begin
                check("ack_halted", {31'd0, halted}, 32'd1);
                check("ack_req_off", {31'd0, bus.imem_req}, 32'd0);
            end else begin
                check("ack_req", {31'd0, bus.imem_req}, 32'd1);
                check("ack_addr", bus.imem_addr, m_pc);
            end
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef FETCH_STATS_EN
        check({tag, "_fetch_cnt"}, fetch_cnt, m_fetch);
        check({tag, "_taken_cnt"}, taken_cnt, m_taken);
`else
        check({tag, "_no_stats_halted"}, {31'd0, halted}, {31'd0, halted === 1'b1});
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        logic hreq;
        reset = 1'b1;
        start = 1'b0;
        halt_req = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ack = 1'b0;
        bus.branch = 1'b0;
        bus.equal = 1'b0;
        bus.branch_offset = '0;
        model_reset();
        tick();
        tick();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", pc, RPC);
        check("rst_instr", bus.instr_out, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_req", {31'd0, bus.imem_req}, 32'd0);
        do_start();

        // Sequential fetches: issue pcs 0, 4, 8, 12.
        for (int k = 0; k < 4; k++) do_fetch(0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("seq_pc", pc, 32'h10);
        do_fetch(1, 0, 1'b1, 1'b1, 16'h0003, 1'b0);
        check("br_taken_pc", pc, 32'h20);
        do_fetch(0, 0, 1'b1, 1'b0, 16'h0003, 1'b0);
        check("br_nt_pc", pc, 32'h24);
        do_fetch(0, 0, 1'b1, 1'b1, 16'hFFFA, 1'b0);
        check("br_back_pc", pc, 32'h10);
        do_fetch(0, 0, 1'b1, 1'b0, 16'h0003, 1'b0);
        check("br_ne_pc", pc, 32'h14);
        do_fetch(0, 0, 1'b1, 1'b1, 16'd10, 1'b0);
        check("to40_pc", pc, 32'h40);
        do_fetch(0, 0, 1'b1, 1'b1, 16'hFFFC, 1'b0);
        check("neg_off_pc", pc, 32'h34);
        do_fetch(0, 0, 1'b1, 1'b1, 16'hFFF1, 1'b0);
        check("top_pc", pc, 32'hFFFF_FFFC);
        do_fetch(0, 0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
        check("wrap_pc", pc, 32'h0);

        // Decode stall with changing memory data, then halt on ack.
        do_fetch(2, 5, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("halt_pc", pc, 32'h4);
        do_start();
        do_fetch(0, 0, 1'b1, 1'b1, 16'd8, 1'b0);
        check("at28_pc", pc, 32'h28);

        // Memory never answers: timeout after TO REQ cycles, pc unchanged.
        do_fetch(TO, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("timeout_pc", pc, 32'h28);
        do_start();
        check("terr_sticky", {31'd0, timeout_err}, 32'd1);
        check_stats("pre_rst");

        // Reset in the middle of a request.
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("mid_rst_pc", pc, RPC);
        check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mid_rst_halted", {31'd0, halted}, 32'd0);
        check("mid_rst_terr", {31'd0, timeout_err}, 32'd0);
        check_stats("mid_rst");
        #2;
        reset = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, bus.imem_req}, 32'd0);

        // Randomized traffic.
        do_start();
        for (int t = 0; t < 80; t++) begin
            lat  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            hreq = ($urandom_range(0, 7) == 0);
            do_fetch(lat, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), hreq);
            if (lat >= TO || hreq) do_start();
        end
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
